// File: rtl/rsa_asip_launcher.sv
// rsa_asip_launcher
//   Front-end control stage for rsa_asip_system. It synchronizes and debounces
//   the raw select/start pushbuttons, synchronizes the sector switches, and then
//   drives the system handshake in order: a one-cycle selected pulse, then a
//   stable sector_select, then a one-cycle start pulse. busy stays high until
//   the done flag rises or the watchdog expires. Button events that arrive
//   during a run are dropped.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   btn_select      raw select pushbutton (async, active-high)
//   btn_start       raw start pushbutton (async, active-high)
//   sw_sector       raw sector switches (async)
//   done            run-complete flag from the system (synchronous to clk)
//   selected        one-cycle pulse to the system
//   start           one-cycle pulse to the system
//   sector_select   sector value latched on the ARMED->SETUP edge
//   busy            high in SETUP, GO and RUN
//   timeout         sticky watchdog-abort flag; cleared on the next SEL
//   state_dbg       FSM state code for the LEDs

// Per-button debouncer. The level is accepted only after DEBOUNCE_CYCLES
// consecutive mismatching samples, so a shorter glitch never reaches the FSM.
module rsa_asip_launcher_db #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,    // already synchronized
    output logic evt     // rising edge of the debounced level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          lvl, lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
            if (din == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // this sample is the DEBOUNCE_CYCLES-th mismatch: accept it
                lvl <= din;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign evt = lvl & ~lvl_q;
endmodule

module rsa_asip_launcher #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int SECTOR_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_select,
    input  logic                btn_start,
    input  logic [SECTOR_W-1:0] sw_sector,
    input  logic                done,
    output logic                selected,
    output logic                start,
    output logic [SECTOR_W-1:0] sector_select,
    output logic                busy,
    output logic                timeout,
    output logic [2:0]          state_dbg
);
    localparam int NUM_BTN = 2;   // [0] select, [1] start
    localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        ARMED = 3'd2,
        SETUP = 3'd3,
        GO    = 3'd4,
        RUN   = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [NUM_BTN-1:0]  btn_s1, btn_s2, evt;
    logic [SECTOR_W-1:0] sw_s1, sw_s2;
    logic [WW-1:0]       wd;
    logic                done_q, done_rise, expire;

    // 2-FF synchronizers for every asynchronous input bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= {btn_start, btn_select};
            btn_s2 <= btn_s1;
            sw_s1  <= sw_sector;
            sw_s2  <= sw_s1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        rsa_asip_launcher_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk (clk),
            .rst (rst),
            .din (btn_s2[g]),
            .evt (evt[g])
        );
    end

    // done is registered unconditionally, so a level already high when RUN
    // is entered is not seen as a completion.
    assign done_rise = done & ~done_q;
    // done_rise on the expiry edge wins: the run completed, no abort.
    assign expire    = (state == RUN) && !done_rise && (wd == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (evt[0]) state_n = SEL;
            SEL:     state_n = ARMED;
            ARMED:   if (evt[0])      state_n = SEL;     // select beats start
                     else if (evt[1]) state_n = SETUP;
            SETUP:   state_n = GO;
            GO:      state_n = RUN;
            RUN:     if (done_rise || expire) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free and
    // line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            selected      <= 1'b0;
            start         <= 1'b0;
            busy          <= 1'b0;
            timeout       <= 1'b0;
            sector_select <= '0;
            wd            <= '0;
            done_q        <= 1'b0;
        end else begin
            state    <= state_n;
            done_q   <= done;
            selected <= (state_n == SEL);
            start    <= (state_n == GO);
            busy     <= (state_n == SETUP) || (state_n == GO) || (state_n == RUN);

            if (state == ARMED && state_n == SETUP)
                sector_select <= sw_s2;

            if (state_n == SEL)
                timeout <= 1'b0;
            else if (expire)
                timeout <= 1'b1;

            if (state == GO)
                wd <= '0;
            else if (state == RUN)
                wd <= wd + 1'b1;
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_rsa_asip_launcher.sv
module tb_rsa_asip_launcher;
    localparam int DB = 4;
    localparam int TO = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_select, btn_start, done;
    logic [SW-1:0] sw_sector;
    logic          selected, start, busy, timeout;
    logic [SW-1:0] sector_select;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    rsa_asip_launcher #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO),
        .SECTOR_W        (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_select    (btn_select),
        .btn_start     (btn_start),
        .sw_sector     (sw_sector),
        .done          (done),
        .selected      (selected),
        .start         (start),
        .sector_select (sector_select),
        .busy          (busy),
        .timeout       (timeout),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s, t, d;
        logic [SW-1:0] w;
        int            n;          // cycles to hold the inputs
        logic [10:0]   exp;        // {state, selected, start, busy, timeout, sector}
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic s, input logic t, input logic [SW-1:0] w,
                                input logic d, input int n, input logic [2:0] es,
                                input logic esel, input logic est, input logic eb,
                                input logic eto, input logic [SW-1:0] esec);
        vec_t v;
        v.s = s; v.t = t; v.w = w; v.d = d; v.n = n;
        v.exp = {es, esel, est, eb, eto, esec};
        vt.push_back(v);
    endfunction

    function automatic logic [10:0] outs();
        return {state_dbg, selected, start, busy, timeout, sector_select};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%b want=%b (state,sel,start,busy,to,sector)", name, act, exp);
        end
    endtask

    // Pulse rules: selected and start never together, never two cycles in a row.
    logic sel_p = 1'b0, st_p = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            sel_p = 1'b0;
            st_p  = 1'b0;
        end else begin
            checks = checks + 1;
            if ((selected && start) || (selected && sel_p) || (start && st_p)) begin
                errors = errors + 1;
                $display("FAIL pulse_rule t=%0t selected=%b start=%b prev=%b%b",
                         $time, selected, start, sel_p, st_p);
            end
            sel_p = selected;
            st_p  = start;
        end
    end

    localparam logic [SW-1:0] A = 4'b1010;
    localparam logic [SW-1:0] B = 4'b0101;

    initial begin
        rst = 1'b1; btn_select = 0; btn_start = 0; done = 0; sw_sector = '0;

        //   sel st  sw  dn  n   state sel st busy to sector
        // nominal run
        add(1, 0, 0, 0, 6,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0);   // 7th edge: selected
        add(1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 2,  2, 0, 0, 0, 0, 0);
        add(0, 0, A, 0, 4,  2, 0, 0, 0, 0, 0);
        add(0, 1, A, 0, 6,  2, 0, 0, 0, 0, 0);
        add(0, 1, A, 0, 1,  3, 0, 0, 1, 0, A);   // SETUP, sector loaded
        add(0, 1, A, 0, 1,  4, 0, 1, 1, 0, A);   // GO, start pulse
        add(0, 1, A, 0, 1,  5, 0, 0, 1, 0, A);
        add(0, 1, A, 0, 1,  5, 0, 0, 1, 0, A);
        add(0, 0, A, 0, 5,  5, 0, 0, 1, 0, A);
        add(0, 0, A, 1, 1,  0, 0, 0, 0, 0, A);   // done rise ends run
        add(0, 0, A, 1, 2,  0, 0, 0, 0, 0, A);
        // start in IDLE ignored
        add(0, 1, A, 0, 10, 0, 0, 0, 0, 0, A);
        add(0, 0, A, 0, 8,  0, 0, 0, 0, 0, A);
        // to ARMED, then 3-cycle start glitch
        add(1, 0, A, 0, 7,  1, 1, 0, 0, 0, A);
        add(0, 0, A, 0, 1,  2, 0, 0, 0, 0, A);
        add(0, 0, A, 0, 8,  2, 0, 0, 0, 0, A);
        add(0, 1, A, 0, 3,  2, 0, 0, 0, 0, A);
        add(0, 0, A, 0, 8,  2, 0, 0, 0, 0, A);
        // simultaneous select+start in ARMED: select wins
        add(1, 1, A, 0, 6,  2, 0, 0, 0, 0, A);
        add(1, 1, A, 0, 1,  1, 1, 0, 0, 0, A);
        add(1, 1, A, 0, 1,  2, 0, 0, 0, 0, A);
        add(0, 0, A, 0, 8,  2, 0, 0, 0, 0, A);
        // run with presses during RUN
        add(0, 1, B, 0, 7,  3, 0, 0, 1, 0, B);
        add(0, 0, B, 0, 1,  4, 0, 1, 1, 0, B);
        add(0, 0, B, 0, 1,  5, 0, 0, 1, 0, B);
        add(1, 1, B, 0, 8,  5, 0, 0, 1, 0, B);
        add(0, 0, B, 1, 1,  0, 0, 0, 0, 0, B);
        add(0, 0, B, 1, 8,  0, 0, 0, 0, 0, B);   // IDLE, not ARMED
        add(0, 0, B, 0, 2,  0, 0, 0, 0, 0, B);
        // watchdog expiry: exactly 16 RUN cycles
        add(1, 0, B, 0, 7,  1, 1, 0, 0, 0, B);
        add(0, 0, B, 0, 8,  2, 0, 0, 0, 0, B);
        add(0, 1, B, 0, 7,  3, 0, 0, 1, 0, B);
        add(0, 0, B, 0, 1,  4, 0, 1, 1, 0, B);
        add(0, 0, B, 0, 1,  5, 0, 0, 1, 0, B);
        add(0, 0, B, 0, 15, 5, 0, 0, 1, 0, B);
        add(0, 0, B, 0, 1,  0, 0, 0, 0, 1, B);
        add(0, 0, B, 0, 3,  0, 0, 0, 0, 1, B);
        add(1, 0, B, 0, 6,  0, 0, 0, 0, 1, B);
        add(1, 0, B, 0, 1,  1, 1, 0, 0, 0, B);   // timeout cleared with selected
        add(0, 0, B, 0, 1,  2, 0, 0, 0, 0, B);
        // done rises on the expiry edge: no timeout
        add(0, 0, B, 0, 8,  2, 0, 0, 0, 0, B);
        add(0, 1, B, 0, 7,  3, 0, 0, 1, 0, B);
        add(0, 0, B, 0, 1,  4, 0, 1, 1, 0, B);
        add(0, 0, B, 0, 1,  5, 0, 0, 1, 0, B);
        add(0, 0, B, 0, 15, 5, 0, 0, 1, 0, B);
        add(0, 0, B, 1, 1,  0, 0, 0, 0, 0, B);
        add(0, 0, B, 0, 2,  0, 0, 0, 0, 0, B);

        repeat (2) @(negedge clk);
        chk("reset_state", outs(), 11'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            btn_select = vt[i].s;
            btn_start  = vt[i].t;
            sw_sector  = vt[i].w;
            done       = vt[i].d;
            repeat (vt[i].n) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end

        // reset mid-run
        btn_select = 1; sw_sector = A;
        repeat (8) @(negedge clk);
        btn_select = 0;
        repeat (8) @(negedge clk);
        btn_start = 1;
        begin
            int k;
            k = 0;
            while (state_dbg !== 3'd5 && k < 40) begin
                @(negedge clk);
                k++;
            end
            checks = checks + 1;
            if (state_dbg !== 3'd5) begin
                errors = errors + 1;
                $display("FAIL reach_run got=%0d want=5", state_dbg);
            end
        end
        btn_start = 0;
        chk("run_sector", outs(), {3'd5, 1'b0, 1'b0, 1'b1, 1'b0, A});
        #1 rst = 1'b1;
        #1 chk("async_reset", outs(), 11'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d", i), outs(), 11'd0);
        end
        btn_select = 1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("reselect", outs(), {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        btn_select = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_asip_launcher.md
Name: rsa_asip_launcher

Overview:
Front-end control stage that sits directly upstream of rsa_asip_system on the board. It synchronizes and debounces the raw select/start pushbuttons and the sector switches, then issues the system's handshake in order: a one-cycle selected pulse, a stable sector_select, then a one-cycle start pulse. It holds busy until the system's done flag (reg15) rises or a watchdog expires, and drops any button presses made while a run is active.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a button level change is accepted (board build overrides to 500000).
TIMEOUT_CYCLES, 1024, maximum cycles spent in RUN before the run is aborted.
SECTOR_W, 4, width of the sector switch bus and sector_select.

Ports:
clk  in  1  system clock, shared with rsa_asip_system
rst  in  1  asynchronous active-high reset
btn_select  in  1  raw select pushbutton, active-high, asynchronous
btn_start  in  1  raw start pushbutton, active-high, asynchronous
sw_sector  in  SECTOR_W  raw sector switches, asynchronous
done  in  1  run-complete flag from rsa_asip_system reg15, synchronous to clk
selected  out  1  one-cycle pulse to rsa_asip_system.selected
start  out  1  one-cycle pulse to rsa_asip_system.start
sector_select  out  SECTOR_W  latched sector value to rsa_asip_system.sector_select
busy  out  1  high from SETUP through RUN
timeout  out  1  sticky watchdog-abort flag
state_dbg  out  3  FSM state code for LEDs

Behaviour:
- Reset: asynchronous. While rst is high, all outputs are 0, the FSM is in IDLE, and all synchronizers, debounced levels, counters and the done-edge register are 0. rst asserted mid-run aborts immediately; no start or selected pulse may be emitted after rst asserts.
- Synchronization: btn_select, btn_start and each sw_sector bit pass through a 2-FF synchronizer.
- Debounce (per button): a counter increments on each cycle where the synchronized level differs from the debounced level and clears when they match. The debounced level flips on the edge where the counter reaches DEBOUNCE_CYCLES. An event is the registered rising edge of the debounced level.
- Latency: from the first clk edge that samples a raw button high, the event is seen by the FSM after DEBOUNCE_CYCLES+2 edges. selected (or the SETUP entry for start) follows on the next edge, for a total of DEBOUNCE_CYCLES+3 edges (7 at default).
- Glitch rejection: a button high for fewer than DEBOUNCE_CYCLES synchronized cycles produces no event.
- done edge: done is registered every cycle regardless of state. done_rise = done & ~done_q. A done level that is already high on RUN entry does not complete the run.
- FSM states and state_dbg codes: IDLE=0, SEL=1, ARMED=2, SETUP=3, GO=4, RUN=5.
  - IDLE: select event -> SEL. start event is ignored.
  - SEL: selected=1 for this single cycle. Clears timeout. -> ARMED.
  - ARMED: select event -> SEL (re-select). Otherwise start event -> SETUP, and sector_select loads the synchronized sw_sector on that edge.
  - SETUP: busy=1, sector_select stable. -> GO.
  - GO: busy=1, start=1 for this single cycle. Watchdog counter cleared. -> RUN.
  - RUN: busy=1. Counter increments each cycle.
    - done_rise -> IDLE.
    - Counter reaches TIMEOUT_CYCLES-1 with no done_rise -> IDLE and timeout set to 1.
    - done_rise on the same edge as expiry -> IDLE, timeout stays 0.
    - All button events in RUN are dropped, not queued.
- Simultaneous select and start events: select wins in IDLE and ARMED, and the start event is discarded.
- sector_select holds its last loaded value outside SETUP and changes only on the ARMED->SETUP edge.
- timeout stays set until the next SEL state or reset.
- selected and start are registered outputs decoded from state. They are never high in the same cycle and never high for two consecutive cycles.

Test Plan:
1. Nominal run: rst high 2 cycles. Hold btn_select high 10 cycles, then sw_sector=4'b1010, then btn_start high 10 cycles. Drive done high 50 cycles after start. Required: selected pulses 1 cycle at edge 7 after the press. sector_select=4'b1010 one cycle before the single-cycle start. busy high from SETUP until the edge after done rises, then state_dbg=0.
2. Glitch: btn_start high 3 cycles in ARMED (DEBOUNCE_CYCLES=4). Required: no SETUP, start stays 0, state_dbg=2.
3. Ignored presses: btn_start in IDLE gives no state change. btn_select and btn_start during RUN give no selected/start pulse; after done, FSM is in IDLE, not ARMED.
4. Watchdog: TIMEOUT_CYCLES=16, done held 0. Required: exactly 16 cycles in RUN, then IDLE with timeout=1. timeout clears on the next selected pulse. Variant with done rising on the expiry edge: timeout stays 0.
5. Simultaneous: both buttons debounced on the same edge in ARMED. Required: SEL, one selected pulse, no start.
6. Reset mid-run: assert rst while in RUN with sector_select=4'b1010. Required: all outputs 0 asynchronously (before the next clk edge). After release, state_dbg=0 and no pulse until a new debounced select.
